// File: rtl/rf_multiport.sv
// rf_multiport: parameterised multi-port register file with write-port priority, per-register busy
// scoreboard and a sequential clear sweep after reset or clr_req. Optional macro: RF_BYPASS_EN.
module rf_multiport #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NR       = 3,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NR*AW-1:0] rf_ra,
  output logic [NR*DW-1:0] rf_rd,
  output logic [NR-1:0]    rf_busy,
  input  logic [NW-1:0]    rf_we,
  input  logic [NW*AW-1:0] rf_wa,
  input  logic [NW*DW-1:0] rf_wd,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic             clr_req,
  output logic             rf_ready,
  input  logic [AW-1:0]    dbg_reg_ra,
  output logic [DW-1:0]    dbg_reg_rd
);

  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [DW-1:0]     mem_d [DEPTH];

  // Read ports plus the debug port share one mux; the debug port sits at index NR.
  logic [AW-1:0]     rd_addr_s [NR+1];
  logic [DW-1:0]     rd_data_s [NR+1];
  logic [NR:0]       rd_busy_s;

  // Register 0 is hard-wired when ZERO_REG is set: its writes and busy marks are dropped.
  function automatic logic wr_ok(input logic [AW-1:0] a);
    return ~(ZR & (a == {AW{1'b0}}));
  endfunction

  // Sweep counter, FSM and scoreboard next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_req) begin
          cnt_d = {AW{1'b0}};
        end else if (cnt_q == AW'(DEPTH-1)) begin
          state_d = ST_READY;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d = cnt_q + AW'(1'b1);
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = {AW{1'b0}};
          busy_d  = {DEPTH{1'b0}};
        end else begin
          for (int i = 0; i < NW; i++) begin
            if (rf_we[i]) begin
              busy_d[rf_wa[i*AW +: AW]] = 1'b0;
            end else begin
              busy_d = busy_d;
            end
          end
          // Set applied after clears: a newly issued producer outranks a retiring one.
          if (sb_set && wr_ok(sb_addr)) begin
            busy_d[sb_addr] = 1'b1;
          end else begin
            busy_d = busy_d;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = {AW{1'b0}};
        busy_d  = {DEPTH{1'b0}};
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {AW{1'b0}};
      busy_q  <= {DEPTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Array next-state: sweep zeroes one entry per cycle, otherwise ascending port order gives port NW-1 priority.
  always_comb begin
    mem_d = mem_q;
    case (state_q)
      ST_CLEAR: begin
        mem_d[cnt_q] = {DW{1'b0}};
      end
      ST_READY: begin
        for (int i = 0; i < NW; i++) begin
          if (rf_we[i] && wr_ok(rf_wa[i*AW +: AW])) begin
            mem_d[rf_wa[i*AW +: AW]] = rf_wd[i*DW +: DW];
          end else begin
            mem_d = mem_d;
          end
        end
      end
      default: begin
        mem_d = mem_q;
      end
    endcase
  end

  // Storage array; left without reset because the sweep defines every entry before it becomes readable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Gather read addresses.
  always_comb begin
    for (int p = 0; p < NR; p++) begin
      rd_addr_s[p] = rf_ra[p*AW +: AW];
    end
    rd_addr_s[NR] = dbg_reg_ra;
  end

  // Read mux: zero while sweeping or for hard-wired register 0, optional same-cycle forwarding.
  always_comb begin
    for (int p = 0; p <= NR; p++) begin
      rd_data_s[p] = {DW{1'b0}};
      rd_busy_s[p] = 1'b0;
      if ((state_q == ST_READY) && wr_ok(rd_addr_s[p])) begin
        rd_data_s[p] = mem_q[rd_addr_s[p]];
        rd_busy_s[p] = busy_q[rd_addr_s[p]];
`ifdef RF_BYPASS_EN
        for (int i = 0; i < NW; i++) begin
          if (rf_we[i] && (rf_wa[i*AW +: AW] == rd_addr_s[p])) begin
            rd_data_s[p] = rf_wd[i*DW +: DW];
            rd_busy_s[p] = sb_set && (sb_addr == rd_addr_s[p]);
          end else begin
            rd_data_s[p] = rd_data_s[p];
          end
        end
`endif
      end else begin
        rd_data_s[p] = {DW{1'b0}};
        rd_busy_s[p] = 1'b0;
      end
    end
  end

  // Output packing.
  always_comb begin
    for (int p = 0; p < NR; p++) begin
      rf_rd[p*DW +: DW] = rd_data_s[p];
      rf_busy[p]        = rd_busy_s[p];
    end
    dbg_reg_rd = rd_data_s[NR];
  end

  assign rf_ready = (state_q == ST_READY);

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: driver pushes model expectations, monitor pops and compares.
module tb_rf_multiport;
  localparam int DW = 32, DEPTH = 32, NR = 3, NW = 2, AW = 5;

  logic clk = 1'b0;
  logic rstn;
  logic [NR*AW-1:0] rf_ra;
  logic [NR*DW-1:0] rf_rd;
  logic [NR-1:0]    rf_busy;
  logic [NW-1:0]    rf_we;
  logic [NW*AW-1:0] rf_wa;
  logic [NW*DW-1:0] rf_wd;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic             clr_req;
  logic             rf_ready;
  logic [AW-1:0]    dbg_reg_ra;
  logic [DW-1:0]    dbg_reg_rd;

  rf_multiport #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
    .clk(clk), .rstn(rstn), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_busy(rf_busy),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .sb_set(sb_set), .sb_addr(sb_addr),
    .clr_req(clr_req), .rf_ready(rf_ready), .dbg_reg_ra(dbg_reg_ra), .dbg_reg_rd(dbg_reg_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             ready;
    logic [NR-1:0]    busy;
    logic [DW-1:0]    dbg;
    logic [NR*DW-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0]    m_mem [DEPTH];
  bit [DEPTH-1:0]   m_busy;
  bit               m_ready;
  int               m_cnt;
  int               sweep_left;

  function automatic bit wr_hits(input logic [AW-1:0] a);
    bit h = 1'b0;
    for (int i = 0; i < NW; i++) if (rf_we[i] && rf_wa[i*AW +: AW] == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    logic [DW-1:0] v = '0;
    if (m_ready && a != 5'd0) begin
      v = m_mem[a];
`ifdef RF_BYPASS_EN
      for (int i = 0; i < NW; i++)
        if (rf_we[i] && rf_wa[i*AW +: AW] == a) v = rf_wd[i*DW +: DW];
`endif
    end
    return v;
  endfunction

  function automatic logic m_busy_rd(input logic [AW-1:0] a);
    logic b = 1'b0;
    if (m_ready && a != 5'd0) begin
      b = m_busy[a];
`ifdef RF_BYPASS_EN
      if (wr_hits(a)) b = sb_set && (sb_addr == a);
`endif
    end
    return b;
  endfunction

  // Model of one rising edge: sweep of DEPTH cycles, then writes and scoreboard rules.
  task automatic m_edge();
    if (!m_ready) begin
      m_mem[m_cnt] = '0;
      if (clr_req) begin
        m_cnt = 0; sweep_left = DEPTH;
      end else begin
        m_cnt = m_cnt + 1;
        sweep_left = sweep_left - 1;
        if (sweep_left == 0) begin m_ready = 1'b1; m_cnt = 0; end
      end
    end else if (clr_req) begin
      m_ready = 1'b0; m_cnt = 0; sweep_left = DEPTH; m_busy = '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (rf_we[i]) begin
          if (rf_wa[i*AW +: AW] != 5'd0) m_mem[rf_wa[i*AW +: AW]] = rf_wd[i*DW +: DW];
          m_busy[rf_wa[i*AW +: AW]] = 1'b0;
        end
      end
      if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
    end
  endtask

  // One cycle: settle, push expectation, advance model, wait for next falling edge.
  task automatic tick();
    exp_t e;
    if (!rstn) begin m_ready = 1'b0; m_cnt = 0; sweep_left = DEPTH; m_busy = '0; end
    #1;
    e.ready = m_ready;
    for (int p = 0; p < NR; p++) begin
      e.rd[p*DW +: DW] = m_read(rf_ra[p*AW +: AW]);
      e.busy[p]        = m_busy_rd(rf_ra[p*AW +: AW]);
    end
    e.dbg = m_read(dbg_reg_ra);
    exp_q.push_back(e);
    if (rstn) m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rf_we = '0; rf_wa = '0; rf_wd = '0; sb_set = 1'b0; sb_addr = '0; clr_req = 1'b0;
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rf_we[i] = 1'b1; rf_wa[i*AW +: AW] = a; rf_wd[i*DW +: DW] = d;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    rf_ra[p*AW +: AW] = a;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_ready", {31'd0, rf_ready}, {31'd0, e.ready});
        for (int p = 0; p < NR; p++) begin
          chk($sformatf("rf_rd%0d", p), rf_rd[p*DW +: DW], e.rd[p*DW +: DW]);
          chk($sformatf("rf_busy%0d", p), {31'd0, rf_busy[p]}, {31'd0, e.busy[p]});
        end
        chk("dbg_reg_rd", dbg_reg_rd, e.dbg);
      end
    end
  end

  // Stimulus
  initial begin
    rstn = 1'b0; rf_ra = '0; dbg_reg_ra = '0; idle();
    for (int r = 0; r < DEPTH; r++) m_mem[r] = '0;
    m_busy = '0; m_ready = 1'b0; m_cnt = 0; sweep_left = DEPTH;
    @(negedge clk);
    repeat (2) tick();
    // Reset mid-sweep, then a full uninterrupted sweep
    rstn = 1'b1;
    repeat (10) tick();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    set_ra(0, 5'd5); set_ra(1, 5'd7); set_ra(2, 5'd9); dbg_reg_ra = 5'd3;
    repeat (DEPTH + 2) tick();

    wr(0, 5'd5, 32'h1234_5678); tick(); idle(); tick();
    set_ra(0, 5'd0); wr(1, 5'd0, 32'hFFFF_FFFF); tick(); idle(); tick(); set_ra(0, 5'd5);
    wr(0, 5'd7, 32'h0000_AAAA); wr(1, 5'd7, 32'h0000_BBBB); tick(); idle(); tick();
    sb_set = 1'b1; sb_addr = 5'd9; tick(); idle(); tick();
    wr(0, 5'd9, 32'h0000_0099); tick(); idle(); tick();
    sb_set = 1'b1; sb_addr = 5'd9; wr(1, 5'd9, 32'h0000_0999); tick(); idle(); tick();
    wr(0, 5'd3, 32'h0000_0055); tick(); idle(); tick();

    // Clear sweep with r5 holding data; writes and busy marks during the sweep are ignored
    clr_req = 1'b1; tick(); idle();
    repeat (DEPTH) begin
      wr(0, 5'd5, 32'hDEAD_BEEF); sb_set = 1'b1; sb_addr = 5'd9; tick(); idle();
    end
    repeat (3) tick();

    // Randomised traffic with clustered addresses to provoke collisions
    repeat (400) begin
      idle();
      for (int p = 0; p < NR; p++) set_ra(p, 5'($urandom_range(0, 15)));
      dbg_reg_ra = 5'($urandom_range(0, 15));
      for (int i = 0; i < NW; i++)
        if ($urandom_range(0, 2) == 0) wr(i, 5'($urandom_range(0, 15)), $urandom);
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_addr = 5'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 79) == 0);
      tick();
    end
    idle();
    repeat (DEPTH + 2) tick();

    repeat (2) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
